// File: rtl/ddr_cmd_issuer_if.sv
// Command encoding shared with the timing controller, and the scheduler <-> issuer signal bundle.
package types_def;
  typedef enum logic [2:0] {
    none        = 3'd0,
    activate    = 3'd1,
    read_cmd    = 3'd2,
    write_cmd   = 3'd3,
    precharge   = 3'd4,
    refresh_all = 3'd5
  } command;
endpackage

interface ddr_cmd_if #(
  parameter int unsigned NO_OF_BURSTS = 4,
  parameter int unsigned CA_W         = 14
);
  import types_def::*;

  localparam int unsigned IDX_W = (NO_OF_BURSTS > 1) ? $clog2(NO_OF_BURSTS) : 1;

  command                           burst_cmd_i;
  logic [IDX_W-1:0]                 cmd_index_i;
  logic [NO_OF_BURSTS-1:0][1:0]     in_burst_address_bg;
  logic [NO_OF_BURSTS-1:0][1:0]     in_burst_address_bank;
  logic [NO_OF_BURSTS-1:0][15:0]    in_burst_address_row;
  logic [NO_OF_BURSTS-1:0][9:0]     in_burst_address_col;
  logic                             cs_n_o;
  logic [CA_W-1:0]                  ca_o;
  logic                             rd_capture_en_o;
  logic [IDX_W-1:0]                 rd_index_o;
  logic                             wr_data_req_o;
  logic [IDX_W-1:0]                 wr_index_o;
  logic                             busy_o;
  logic                             proto_err_o;

  modport slave (
    input  burst_cmd_i, cmd_index_i,
    input  in_burst_address_bg, in_burst_address_bank,
    input  in_burst_address_row, in_burst_address_col,
    output cs_n_o, ca_o, rd_capture_en_o, rd_index_o,
    output wr_data_req_o, wr_index_o, busy_o, proto_err_o
  );

  modport master (
    output burst_cmd_i, cmd_index_i,
    output in_burst_address_bg, in_burst_address_bank,
    output in_burst_address_row, in_burst_address_col,
    input  cs_n_o, ca_o, rd_capture_en_o, rd_index_o,
    input  wr_data_req_o, wr_index_o, busy_o, proto_err_o
  );
endinterface

// File: rtl/ddr_cmd_issuer.sv
// Serialises scheduled DRAM commands into 3-phase CA words and tracks the
// read-capture / write-data windows that follow each column command.
module ddr_cmd_issuer
  import types_def::*;
#(
  parameter int unsigned NO_OF_BURSTS = 4,
  parameter int unsigned CA_W         = 14,
  parameter int unsigned RL           = 6,
  parameter int unsigned WL           = 5,
  parameter int unsigned BURST_LEN    = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  ddr_cmd_if.slave  bus
);

  localparam int unsigned IDX_W = (NO_OF_BURSTS > 1) ? $clog2(NO_OF_BURSTS) : 1;
  localparam int unsigned RD_D  = RL + BURST_LEN;
  localparam int unsigned WR_D  = WL + BURST_LEN;
  localparam int unsigned SD    = (RD_D > WR_D) ? RD_D : WR_D;

  // Slot j of a schedule register is the cycle j cycles after the current one.
  localparam logic [RD_D-1:0] RD_MASK = {{BURST_LEN{1'b1}}, {RL{1'b0}}};
  localparam logic [WR_D-1:0] WR_MASK = {1'b0, {BURST_LEN{1'b1}}, {(WL-1){1'b0}}};

  localparam logic [2:0] OP_ACT = 3'b001;
  localparam logic [2:0] OP_RD  = 3'b010;
  localparam logic [2:0] OP_WR  = 3'b011;
  localparam logic [2:0] OP_PRE = 3'b100;
  localparam logic [2:0] OP_REF = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PH1  = 2'd1,
    S_PH2  = 2'd2
  } state_e;

  function automatic logic [2:0] op_of(input command c);
    case (c)
      activate:    op_of = OP_ACT;
      read_cmd:    op_of = OP_RD;
      write_cmd:   op_of = OP_WR;
      precharge:   op_of = OP_PRE;
      refresh_all: op_of = OP_REF;
      default:     op_of = 3'b000;
    endcase
  endfunction

  state_e                   state_q, state_d;
  command                   cmd_q, cmd_d;
  logic [15:0]              row_q, row_d;
  logic [9:0]               col_q, col_d;
  logic                     cs_n_q, cs_n_d;
  logic [CA_W-1:0]          ca_q, ca_d;
  logic                     busy_q, busy_d;
  logic                     err_q, err_d;
  logic [RD_D-1:0]          rd_v_q, rd_v_d;
  logic [RD_D-1:0][IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [WR_D-1:0]          wr_v_q, wr_v_d;
  logic [WR_D-1:0][IDX_W-1:0] wr_idx_q, wr_idx_d;

  logic [1:0]               sel_bg, sel_bank;
  logic [15:0]              sel_row;
  logic [9:0]               sel_col;
  logic [13:0]              ph_word;
  logic                     accept, drop;
  logic                     is_rd, is_wr, collide;
  logic [SD-1:0]            occupied, new_win;

  assign sel_bg   = bus.in_burst_address_bg[bus.cmd_index_i];
  assign sel_bank = bus.in_burst_address_bank[bus.cmd_index_i];
  assign sel_row  = bus.in_burst_address_row[bus.cmd_index_i];
  assign sel_col  = bus.in_burst_address_col[bus.cmd_index_i];

  // CA phase sequencer: phase 0 is built from the live inputs, phases 1/2 from the latched command.
  always_comb begin : fsm_comb
    state_d = state_q;
    cmd_d   = cmd_q;
    row_d   = row_q;
    col_d   = col_q;
    cs_n_d  = 1'b1;
    ph_word = '0;
    accept  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.burst_cmd_i != none) begin
          accept  = 1'b1;
          state_d = S_PH1;
          cmd_d   = bus.burst_cmd_i;
          row_d   = sel_row;
          col_d   = sel_col;
          cs_n_d  = 1'b0;
          if (bus.burst_cmd_i == refresh_all) ph_word = {OP_REF, 11'b0};
          else ph_word = {op_of(bus.burst_cmd_i), sel_bg, sel_bank, 7'b0};
        end
      end
      S_PH1: begin
        drop    = (bus.burst_cmd_i != none);
        state_d = S_PH2;
        case (cmd_q)
          activate:            ph_word = {6'b0, row_q[15:8]};
          read_cmd, write_cmd: ph_word = {8'b0, col_q[9:4]};
          default:             ph_word = '0;
        endcase
      end
      S_PH2: begin
        drop    = (bus.burst_cmd_i != none);
        state_d = S_IDLE;
        case (cmd_q)
          activate:            ph_word = {6'b0, row_q[7:0]};
          read_cmd, write_cmd: ph_word = {10'b0, col_q[3:0]};
          default:             ph_word = '0;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    ca_d   = CA_W'(ph_word);
  end

  // Data-window scheduling; reads and writes share the DQ bus so both registers guard each other.
  always_comb begin : win_comb
    rd_v_d   = rd_v_q >> 1;
    wr_v_d   = wr_v_q >> 1;
    rd_idx_d = rd_idx_q >> IDX_W;
    wr_idx_d = wr_idx_q >> IDX_W;
    is_rd    = accept && (bus.burst_cmd_i == read_cmd);
    is_wr    = accept && (bus.burst_cmd_i == write_cmd);
    occupied = SD'(rd_v_d) | SD'(wr_v_d);
    new_win  = '0;
    if (is_rd) new_win = SD'(RD_MASK);
    else if (is_wr) new_win = SD'(WR_MASK);
    collide  = |(occupied & new_win);
    if (!collide && is_rd) begin
      rd_v_d = rd_v_d | RD_MASK;
      for (int j = 0; j < int'(RD_D); j++) begin
        if (RD_MASK[j]) rd_idx_d[j] = bus.cmd_index_i;
      end
    end
    if (!collide && is_wr) begin
      wr_v_d = wr_v_d | WR_MASK;
      for (int j = 0; j < int'(WR_D); j++) begin
        if (WR_MASK[j]) wr_idx_d[j] = bus.cmd_index_i;
      end
    end
    err_d = err_q | drop | collide;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cmd_q    <= none;
      row_q    <= '0;
      col_q    <= '0;
      cs_n_q   <= 1'b1;
      ca_q     <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_v_q   <= '0;
      rd_idx_q <= '0;
      wr_v_q   <= '0;
      wr_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cs_n_q   <= cs_n_d;
      ca_q     <= ca_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      rd_v_q   <= rd_v_d;
      rd_idx_q <= rd_idx_d;
      wr_v_q   <= wr_v_d;
      wr_idx_q <= wr_idx_d;
    end
  end

  assign bus.cs_n_o          = cs_n_q;
  assign bus.ca_o            = ca_q;
  assign bus.busy_o          = busy_q;
  assign bus.proto_err_o     = err_q;
  assign bus.rd_capture_en_o = rd_v_q[0];
  assign bus.rd_index_o      = rd_idx_q[0];
  assign bus.wr_data_req_o   = wr_v_q[0];
  assign bus.wr_index_o      = wr_idx_q[0];

endmodule
